// File: rtl/spike_train_encoder_pkg.sv
// Shared definitions for the spike train encoder.
// Holds the encoder FSM state type and the default geometry, which the
// first neuron layer also uses for its INPUTS width so both sides agree.
package spike_train_encoder_pkg;

  localparam int RATE_W_DEF   = 8;
  localparam int WINDOW_W_DEF = 8;
  localparam int CHANNELS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/spike_phase_acc.sv
// One channel of the rate encoder: a phase accumulator whose carry out is
// the spike. Adding RATE every enabled cycle makes the carry fire exactly
// RATE times per 2^RATE_W samples.
// Ports:
//   CLK   clock, rising edge
//   RST   synchronous active-high reset (accumulator and spike to 0)
//   CLR   clear accumulator and spike (start of a window)
//   EN    accumulate this cycle and register the carry as SPIKE
//   RATE  per-channel rate
//   SPIKE registered spike bit; 0 on every cycle that is not enabled
module spike_phase_acc #(
  parameter int RATE_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR,
  input  logic              EN,
  input  logic [RATE_W-1:0] RATE,
  output logic              SPIKE
);

  logic [RATE_W-1:0] acc_q, acc_d;
  logic              spike_q, spike_d;
  logic [RATE_W:0]   sum;

  // NOTE: every signal written here gets a default before any branch, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, RATE};
    acc_d   = acc_q;
    spike_d = 1'b0;
    if (CLR) begin
      acc_d = '0;
    end else if (EN) begin
      // Wrap-around is the point: the dropped carry is the spike.
      acc_d   = sum[RATE_W-1:0];
      spike_d = sum[RATE_W];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q   <= '0;
      spike_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      spike_q <= spike_d;
    end
  end

  assign SPIKE = spike_q;

endmodule

// File: rtl/spike_train_encoder.sv
// Rate-coded spike train generator feeding the first neuron layer.
// The host loads one rate per channel, then pulses START; the block emits
// WINDOW_LEN registered spike samples and pulses DONE.
// Ports:
//   CLK, RST             clock and synchronous active-high reset
//   WR_EN/WR_ADDR/WR_DATA rate register write port (ignored while BUSY)
//   START, WINDOW_LEN    begin a window of WINDOW_LEN samples (ignored while BUSY)
//   BUSY                 high from the START edge through the DONE cycle
//   DONE                 one-cycle pulse after the last sample
//   SPIKE_VALID          high while SPIKE_OUT carries a window sample
//   SPIKE_OUT            registered spike bits, one per channel
module spike_train_encoder
  import spike_train_encoder_pkg::*;
#(
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int RATE_W   = RATE_W_DEF,
  parameter int WINDOW_W = WINDOW_W_DEF
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        WR_EN,
  input  logic [$clog2(CHANNELS)-1:0] WR_ADDR,
  input  logic [RATE_W-1:0]           WR_DATA,
  input  logic                        START,
  input  logic [WINDOW_W-1:0]         WINDOW_LEN,
  output logic                        BUSY,
  output logic                        DONE,
  output logic                        SPIKE_VALID,
  output logic [CHANNELS-1:0]         SPIKE_OUT
);

  localparam int ADDR_W = $clog2(CHANNELS);

  state_e              state_q, state_d;
  logic [WINDOW_W-1:0] len_q, len_d;
  logic [WINDOW_W-1:0] cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic [RATE_W-1:0]   rate_q [CHANNELS];
  logic [RATE_W-1:0]   rate_d [CHANNELS];
  logic                acc_clr;
  logic                acc_en;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = 1'b0;
    rate_d  = rate_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The DONE cycle is spent in IDLE with BUSY still high; BUSY drops
        // at its end, and nothing is accepted until then.
        busy_d = 1'b0;
        if (!busy_q) begin
          // Addresses at or above CHANNELS match no entry and are dropped.
          if (WR_EN) begin
            for (int c = 0; c < CHANNELS; c++) begin
              if (WR_ADDR == ADDR_W'(c)) rate_d[c] = WR_DATA;
            end
          end
          if (START) begin
            len_d   = WINDOW_LEN;
            cnt_d   = '0;
            acc_clr = 1'b1;
            busy_d  = 1'b1;
            state_d = (WINDOW_LEN == '0) ? FIN : RUN;
          end
        end
      end
      RUN: begin
        // cnt_q == 0 is the lead-in cycle that lines the first registered
        // sample up two edges after START; samples 1..len follow.
        if (cnt_q != '0) begin
          acc_en  = 1'b1;
          valid_d = 1'b1;
        end
        if (cnt_q == len_q) state_d = FIN;
        else                cnt_d   = cnt_q + 1'b1;
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      // NOTE: this small register file is reset on purpose: a window
      // started right after reset must see defined all-zero rates.
      for (int c = 0; c < CHANNELS; c++) rate_q[c] <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      rate_q  <= rate_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    spike_phase_acc #(
      .RATE_W(RATE_W)
    ) u_acc (
      .CLK  (CLK),
      .RST  (RST),
      .CLR  (acc_clr),
      .EN   (acc_en),
      .RATE (rate_q[c]),
      .SPIKE(SPIKE_OUT[c])
    );
  end

  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign SPIKE_VALID = valid_q;

endmodule

// File: tb/tb_spike_train_encoder.sv
// Self-checking bench for spike_train_encoder. Expected spikes come from the
// closed form: sample k (1-based) of rate r spikes iff
// floor(k*r/256) != floor((k-1)*r/256).
module tb_spike_train_encoder;

  localparam int CH = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       WR_EN = 1'b0;
  logic [2:0] WR_ADDR = '0;
  logic [7:0] WR_DATA = '0;
  logic       START = 1'b0;
  logic [7:0] WINDOW_LEN = '0;
  logic       BUSY;
  logic       DONE;
  logic       SPIKE_VALID;
  logic [7:0] SPIKE_OUT;

  int checks = 0;
  int failures = 0;
  int model_rate [CH];
  int spike_count [CH];

  spike_train_encoder #(
    .CHANNELS(CH),
    .RATE_W  (8),
    .WINDOW_W(8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .WR_EN      (WR_EN),
    .WR_ADDR    (WR_ADDR),
    .WR_DATA    (WR_DATA),
    .START      (START),
    .WINDOW_LEN (WINDOW_LEN),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .SPIKE_VALID(SPIKE_VALID),
    .SPIKE_OUT  (SPIKE_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; outputs are stable 1 time unit later.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] expected_spikes(input int k);
    logic [7:0] v;
    v = '0;
    for (int c = 0; c < CH; c++)
      v[c] = (((k * model_rate[c]) / 256) != (((k - 1) * model_rate[c]) / 256));
    return v;
  endfunction

  task automatic write_rate(input int addr, input int data);
    WR_EN   = 1'b1;
    WR_ADDR = addr[2:0];
    WR_DATA = data[7:0];
    tick();
    WR_EN = 1'b0;
    model_rate[addr] = data;
  endtask

  // Runs one window and checks every cycle of it. Optional: a write issued
  // together with START, an ignored write+START at sample 1, or a reset
  // asserted during sample abort_at.
  task automatic run_window(input int len, input bit wr_now, input int waddr,
                            input int wdata, input bit interfere, input int abort_at);
    logic [7:0] exp_v;
    for (int c = 0; c < CH; c++) spike_count[c] = 0;
    START      = 1'b1;
    WINDOW_LEN = len[7:0];
    if (wr_now) begin
      WR_EN   = 1'b1;
      WR_ADDR = waddr[2:0];
      WR_DATA = wdata[7:0];
    end
    tick();
    START = 1'b0;
    WR_EN = 1'b0;
    if (wr_now) model_rate[waddr] = wdata;
    check("busy_rise", BUSY, 1);
    check("valid_at_start", SPIKE_VALID, 0);
    check("done_at_start", DONE, 0);
    if (len != 0) begin
      tick();
      check("lead_valid", SPIKE_VALID, 0);
      check("lead_spike", SPIKE_OUT, 0);
      for (int k = 1; k <= len; k++) begin
        tick();
        if (interfere && k == 2) begin
          WR_EN = 1'b0;
          START = 1'b0;
        end
        exp_v = expected_spikes(k);
        check("valid", SPIKE_VALID, 1);
        check("spike", SPIKE_OUT, exp_v);
        check("done_mid", DONE, 0);
        check("busy_mid", BUSY, 1);
        for (int c = 0; c < CH; c++) spike_count[c] += int'(SPIKE_OUT[c]);
        if (interfere && k == 1) begin
          WR_EN      = 1'b1;
          WR_ADDR    = 3'd0;
          WR_DATA    = 8'hFF;
          START      = 1'b1;
          WINDOW_LEN = 8'd3;
        end
        if (k == abort_at) begin
          RST = 1'b1;
          tick();
          RST = 1'b0;
          check("abort_busy", BUSY, 0);
          check("abort_done", DONE, 0);
          check("abort_valid", SPIKE_VALID, 0);
          check("abort_spike", SPIKE_OUT, 0);
          for (int c = 0; c < CH; c++) model_rate[c] = 0;
          return;
        end
      end
    end
    tick();
    check("done_pulse", DONE, 1);
    check("fin_valid", SPIKE_VALID, 0);
    check("fin_spike", SPIKE_OUT, 0);
    check("busy_in_done", BUSY, 1);
    tick();
    check("done_fall", DONE, 0);
    check("busy_fall", BUSY, 0);
    check("idle_valid", SPIKE_VALID, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < CH; c++) model_rate[c] = 0;
    tick();
    tick();
    RST = 1'b0;
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_valid", SPIKE_VALID, 0);
    check("rst_spike", SPIKE_OUT, 0);

    // Half rate: alternating 0,1 on channel 0.
    write_rate(0, 128);
    run_window(8, 0, 0, 0, 0, 0);
    check("ch0_half_count", spike_count[0], 4);

    // Full, zero and quarter rates.
    write_rate(1, 255);
    write_rate(2, 0);
    write_rate(3, 64);
    run_window(4, 0, 0, 0, 0, 0);
    check("ch1_full_count", spike_count[1], 3);
    check("ch2_zero_count", spike_count[2], 0);
    check("ch3_quarter_count", spike_count[3], 1);

    // Empty window, then a normal one.
    run_window(0, 0, 0, 0, 0, 0);
    run_window(3, 0, 0, 0, 0, 0);

    // Write and START during RUN are ignored; rate 128 persists.
    run_window(6, 0, 0, 0, 1, 0);
    run_window(4, 0, 0, 0, 0, 0);
    check("ch0_locked_count", spike_count[0], 2);
    write_rate(0, 255);
    run_window(4, 0, 0, 0, 0, 0);
    check("ch0_rewritten_count", spike_count[0], 3);

    // Reset during the 3rd sample of an 8-sample window.
    run_window(8, 0, 0, 0, 0, 3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_abort_done", DONE, 0);
      check("post_abort_busy", BUSY, 0);
    end
    run_window(8, 0, 0, 0, 0, 0);
    for (int c = 0; c < CH; c++) check("post_abort_count", spike_count[c], 0);

    // Write together with START, longest window.
    run_window(255, 1, 5, 200, 0, 0);
    check("ch5_long_count", spike_count[5], 199);

    // Randomized windows.
    for (int it = 0; it < 8; it++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 1) == 1) write_rate(c, int'($urandom_range(0, 255)));
      end
      run_window(int'($urandom_range(0, 40)), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 255)),
                 bit'($urandom_range(0, 1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
